// File: rtl/mod_adc_capture_pkg.sv
// Shared definitions for the ADC capture front-end: FSM state encodings,
// default word width and the saturation codes of a 16-bit offset-binary ADC.
package mod_adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    READ = 2'd2
  } adcState_t;

  localparam int DATA_W_DEF = 16;

  localparam logic [DATA_W_DEF-1:0] SAT_LO = 16'h0000;
  localparam logic [DATA_W_DEF-1:0] SAT_HI = 16'hFFFF;

  // A word at either rail means the analog input is clipped.
  function automatic logic isSatWord(input logic [DATA_W_DEF-1:0] word);
    return (word == SAT_LO) || (word == SAT_HI);
  endfunction

endpackage

// File: rtl/mod_adc_capture_tick.sv
// Enable-gated sample-rate timer for the ADC capture front-end.
// Counts 0..SAMPLE_PERIOD-1 while enabled, sits at 0 while disabled, and
// raises pTick (combinational) whenever it is enabled and at count 0.
module mod_sample_tick #(
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic pClk,
  input  logic pRst,
  input  logic pEnable,
  output logic pTick
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [TW-1:0] timer;

  // Free-running period counter, parked at 0 whenever the timer is disabled.
  always_ff @(posedge pClk) begin
    if (!pRst) begin
      timer <= '0;
    end else if (!pEnable) begin
      timer <= '0;
    end else if (timer == TW'(SAMPLE_PERIOD - 1)) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign pTick = pEnable && (timer == '0);

endmodule

// File: rtl/mod_adc_capture.sv
// Serial ADC front-end: paces conversions with mod_sample_tick, drives CNV and
// SCLK from registers, shifts the result in MSB-first and presents a
// registered sample with a one-cycle valid strobe.
// Optional build macro ADC_SAT_DETECT_EN adds the registered saturation flag;
// without it pAdcSat is tied low.
// pAdcValid is a one-cycle strobe with no ready: the consumer must take
// pAdcData in the cycle pAdcValid is high; pAdcData then holds until the next.
module mod_adc_capture
  import mod_adc_capture_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int CONV_CYCLES   = 100,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int DATA_W        = DATA_W_DEF
) (
  input  logic              pClk,
  input  logic              pRst,
  input  logic              pEnable,
  input  logic              pAdcSdo,
  output logic              pAdcCnv,
  output logic              pAdcSclk,
  output logic [DATA_W-1:0] pAdcData,
  output logic              pAdcValid,
  output logic              pAdcBusy,
  output logic              pAdcOverrun,
  output logic              pAdcSat
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(DATA_W);

  adcState_t         state, stateNext;
  logic [CW-1:0]     convCnt, convNext;
  logic [PW-1:0]     phaseCnt, phaseNext;
  logic [BW-1:0]     bitCnt, bitNext;
  // Only DATA_W-1 bits are stored; the final bit joins them on capture.
  logic [DATA_W-2:0] shiftReg, shiftNext;
  logic [DATA_W-1:0] capWord;
  logic              capture;
  logic              tick;

  logic              cnvReg, sclkReg, validReg, overrunReg;
  logic [DATA_W-1:0] dataReg;

  mod_sample_tick #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) uTick (
    .pClk   (pClk),
    .pRst   (pRst),
    .pEnable(pEnable),
    .pTick  (tick)
  );

  assign capWord = {shiftReg, pAdcSdo};

  // Next-state logic: conversion wait, then DATA_W SCLK slots of 2*CLK_DIV cycles.
  always_comb begin
    stateNext = state;
    convNext  = convCnt;
    phaseNext = phaseCnt;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          stateNext = CONV;
          convNext  = '0;
        end
      end
      CONV: begin
        if (convCnt == CW'(CONV_CYCLES - 1)) begin
          stateNext = READ;
          phaseNext = '0;
          bitNext   = '0;
        end else begin
          convNext = convCnt + 1'b1;
        end
      end
      READ: begin
        if (phaseCnt == PW'(2 * CLK_DIV - 1)) begin
          // Last high cycle of the slot: SDO has been stable since SCLK rose.
          shiftNext = capWord[DATA_W-2:0];
          phaseNext = '0;
          if (bitCnt == BW'(DATA_W - 1)) begin
            stateNext = IDLE;
            capture   = 1'b1;
          end else begin
            bitNext = bitCnt + 1'b1;
          end
        end else begin
          phaseNext = phaseCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM state and datapath counters.
  always_ff @(posedge pClk) begin
    if (!pRst) begin
      state    <= IDLE;
      convCnt  <= '0;
      phaseCnt <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      convCnt  <= convNext;
      phaseCnt <= phaseNext;
      bitCnt   <= bitNext;
      shiftReg <= shiftNext;
    end
  end

  // Pin and result registers, computed from next state so pins align with the FSM.
  always_ff @(posedge pClk) begin
    if (!pRst) begin
      cnvReg     <= 1'b0;
      sclkReg    <= 1'b0;
      validReg   <= 1'b0;
      overrunReg <= 1'b0;
      dataReg    <= '0;
    end else begin
      cnvReg     <= (stateNext == CONV);
      sclkReg    <= (stateNext == READ) && (phaseNext >= PW'(CLK_DIV));
      validReg   <= capture;
      overrunReg <= tick && (state != IDLE);
      if (capture) begin
        dataReg <= capWord;
      end
    end
  end

`ifdef ADC_SAT_DETECT_EN
  logic satReg;

  // Saturation flag tracks the captured word and changes only on valid cycles.
  always_ff @(posedge pClk) begin
    if (!pRst) begin
      satReg <= 1'b0;
    end else if (capture) begin
      satReg <= isSatWord(capWord);
    end
  end

  assign pAdcSat = satReg;
`else
  assign pAdcSat = 1'b0;
`endif

  assign pAdcCnv     = cnvReg;
  assign pAdcSclk    = sclkReg;
  assign pAdcData    = dataReg;
  assign pAdcValid   = validReg;
  assign pAdcOverrun = overrunReg;
  assign pAdcBusy    = (state != IDLE);

endmodule
